// File: rtl/wave_key_ctrl_if.sv
// Board-side bundle of the wave generator front end: five raw push-buttons in,
// display/datapath parameters out.
interface wave_key_ctrl_if;
   logic       key_wave;
   logic       key_fup;
   logic       key_fdn;
   logic       key_aup;
   logic       key_adn;
   logic       clk_seg;
   logic [1:0] dispdata;
   logic [7:0] dispfreqz;
   logic [3:0] Amp;
   logic       param_upd;

   modport master (
      output key_wave, key_fup, key_fdn, key_aup, key_adn,
      input  clk_seg, dispdata, dispfreqz, Amp, param_upd
   );

   modport slave (
      input  key_wave, key_fup, key_fdn, key_aup, key_adn,
      output clk_seg, dispdata, dispfreqz, Amp, param_upd
   );
endinterface

// File: rtl/wave_key_ctrl.sv
// Push-button front end: synchronise, debounce and auto-repeat five keys, then
// maintain waveform select, BCD frequency code, amplitude and the scan clock.
module wave_key_ctrl #(
   parameter int DB_CYCLES  = 2_000_000,
   parameter int SEG_DIV    = 50_000,
   parameter int REPEAT_DLY = 50_000_000,
   parameter int REPEAT_PER = 10_000_000,
   parameter int AMP_RST    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   wave_key_ctrl_if.slave  io
);

   localparam int DBW     = $clog2(DB_CYCLES + 1);
   localparam int SGW     = $clog2(SEG_DIV + 1);
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int HW      = $clog2(REP_MAX + 1);

   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [SGW-1:0] SEG_LAST = SGW'(SEG_DIV - 1);
   localparam logic [HW-1:0]  DLY_T    = HW'(REPEAT_DLY);
   localparam logic [HW-1:0]  PER_T    = HW'(REPEAT_PER);

   function automatic logic [7:0] bcd_inc(input logic [7:0] f);
      if (f == 8'h99)        return f;
      if (f[3:0] == 4'd9)    return {f[7:4] + 4'd1, 4'd0};
      return {f[7:4], f[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] f);
      if (f == 8'h01)        return f;
      if (f[3:0] == 4'd0)    return {f[7:4] - 4'd1, 4'd9};
      return {f[7:4], f[3:0] - 4'd1};
   endfunction

   function automatic logic [3:0] amp_inc(input logic [3:0] a);
      return (a == 4'd15) ? a : a + 4'd1;
   endfunction

   function automatic logic [3:0] amp_dec(input logic [3:0] a);
      return (a <= 4'd1) ? a : a - 4'd1;
   endfunction

   // Key order: 0 wave, 1 freq up, 2 freq down, 3 amp up, 4 amp down
   logic [4:0]     raw_keys;
   logic [4:0]     sync_p0, sync_p1;
   logic [4:0]     stable, stable_q;
   logic [DBW-1:0] db_cnt [5];
   logic [HW-1:0]  hold [2];
   logic [1:0]     rep_on, rep_hit;
   logic [4:0]     evt;

   assign raw_keys = {io.key_adn, io.key_aup, io.key_fdn, io.key_fup, io.key_wave};

   // Stage p0/p1: two-flop synchroniser, then debounce to a stable level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0  <= raw_keys;
         sync_p1  <= sync_p0;
         stable_q <= stable;
         for (int i = 0; i < 5; i++) begin
            if (sync_p1[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // Hold counters for the two frequency keys; after the first repeat the target drops to the period
   always_comb begin
      rep_hit = '0;
      for (int f = 0; f < 2; f++)
         rep_hit[f] = stable[f+1] && (hold[f] == (rep_on[f] ? PER_T : DLY_T));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_on <= '0;
         for (int f = 0; f < 2; f++) hold[f] <= '0;
      end else begin
         for (int f = 0; f < 2; f++) begin
            if (!stable[f+1]) begin
               hold[f]   <= '0;
               rep_on[f] <= 1'b0;
            end else if (rep_hit[f]) begin
               hold[f]   <= HW'(1);
               rep_on[f] <= 1'b1;
            end else begin
               hold[f] <= hold[f] + HW'(1);
            end
         end
      end
   end

   assign evt = (stable & ~stable_q) | {2'b00, rep_hit, 1'b0};

   logic [1:0] data_r, data_nx;
   logic [7:0] freq_r, freq_nx;
   logic [3:0] amp_r, amp_nx;
   logic       upd_r, changed;
   logic       seg_r;
   logic [SGW-1:0] seg_cnt;

   // Opposite events on the same parameter cancel; different parameters apply together
   always_comb begin
      data_nx = data_r;
      freq_nx = freq_r;
      amp_nx  = amp_r;
      if (evt[0]) data_nx = data_r + 2'd1;
      if (evt[1] && !evt[2])      freq_nx = bcd_inc(freq_r);
      else if (evt[2] && !evt[1]) freq_nx = bcd_dec(freq_r);
      if (evt[3] && !evt[4])      amp_nx = amp_inc(amp_r);
      else if (evt[4] && !evt[3]) amp_nx = amp_dec(amp_r);
      changed = (data_nx != data_r) || (freq_nx != freq_r) || (amp_nx != amp_r);
   end

   // Stage p2: registered parameters and update strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= 2'd0;
         freq_r <= 8'h01;
         amp_r  <= 4'(AMP_RST);
         upd_r  <= 1'b0;
      end else begin
         data_r <= data_nx;
         freq_r <= freq_nx;
         amp_r  <= amp_nx;
         upd_r  <= changed;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_cnt <= '0;
         seg_r   <= 1'b0;
      end else if (seg_cnt == SEG_LAST) begin
         seg_cnt <= '0;
         seg_r   <= ~seg_r;
      end else begin
         seg_cnt <= seg_cnt + SGW'(1);
      end
   end

   assign io.dispdata  = data_r;
   assign io.dispfreqz = freq_r;
   assign io.Amp       = amp_r;
   assign io.param_upd = upd_r;
   assign io.clk_seg   = seg_r;

endmodule
